ripple_count_capture: RTL and testbench
=======================================

// Module: ripple_count_capture
// PURPOSE
//  Downstream consumer of the 4-bit ripple (asynchronous) counter output.
//  - Samples the glitch-prone count into the system clock domain.
//  - Accepts a value only once it is stable, and accumulates it into a wide extended count across 15->0 wraps.
//  - Presents each update on a valid/ready output with overrun detection.
//  - Sits between the ripple counter and any synchronous logic that reads event totals.
// PARAMETERS
//  WIDTH    16  extended count width (>=5); wraps modulo 2^WIDTH
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  cnt_in     in   4      raw ripple-counter output (asynchronous to clk)
//  cmp_val    in   WIDTH  compare value for match pulse
//  out_ready  in   1      consumer ready
//  out_valid  out  1      out_data holds an unconsumed update
//  out_data   out  WIDTH  extended count after latest accepted update
//  wrap       out  1      1-cycle pulse: accepted update crossed 15->0
//  match      out  1      1-cycle pulse: updated extended count == cmp_val
//  overrun    out  1      sticky: an update overwrote an unconsumed out_data
// BEHAVIOUR
//  Reset (rst high at a clk edge): all registers cleared.
//   - s1, s2, s3, last = 0; ext = 0.
//   - out_valid = 0; out_data = 0; wrap = match = overrun = 0.
//   - rst has priority over every other event.
//  Sync pipe: s1 <= cnt_in; s2 <= s1; s3 <= s2 (4-bit each).
//  Stable: s2 == s3.
//  Accept: stable && (s2 != last), evaluated each cycle.
//   - On accept: delta = (s2 - last) mod 16 (4-bit wrap subtraction, range 1..15).
//   - ext <= ext + delta (WIDTH-bit, modulo 2^WIDTH).
//   - last <= s2.
//   - wrap pulses 1 cycle when s2 < last.
//   - match pulses 1 cycle when (ext + delta) == cmp_val.
//   - out_data <= ext + delta.
//  Latency: cnt_in changes before edge k and is held. Then:
//   - s1 updates at k, s2 at k+1, s3 at k+2.
//   - Accept occurs at edge k+3: out_data, out_valid, wrap and match are visible after k+3.
//  Instability: if cnt_in changes again before s2 == s3, no accept occurs. Glitches shorter than 2 cycles are filtered.
//  Output FSM, states IDLE and PEND:
//   - IDLE: out_valid = 0. Accept -> PEND.
//   - PEND: out_valid = 1.
//     - out_ready && !accept -> IDLE.
//     - out_ready && accept -> stay PEND with new data; no overrun.
//     - !out_ready && accept -> stay PEND, out_data overwritten, overrun <= 1.
//   - out_data is stable while out_valid && !out_ready, except on overrun.
//  overrun: cleared only by rst.
//  Skipped counts: a delta > 1 (slow sampling) is added whole.
//   - wrap still fires once per crossing of 15->0; a delta of 16 or more is undetectable.
//  Reset mid-operation: last = 0 after reset.
//   - A nonzero held cnt_in is accepted 3 cycles after rst deasserts, with delta = cnt_in.
//   - wrap stays 0 for that accept.
//  Extended-count rollover: ext rolls 2^WIDTH-1 -> 0 silently. wrap reflects only 4-bit wraps.
// STRUCTURE
//  Package cnt_capture_pkg holds:
//   - CNT_W = 4.
//   - The output state enum {IDLE, PEND}.
//   - A helper function delta4(new, old) returning a 4-bit modulo difference.
//  Sub-module sync_3ff #(W) holds the s1/s2/s3 chain with synchronous reset and outputs s2, s3.
//  Top level: accept/accumulate logic, output FSM and flags.
// TESTING
//  1. rst 2 cycles, cnt_in=0 -> all outputs 0, no accept.
//  2. cnt_in 0->1 before edge k, hold -> out_valid=1 and out_data=1 after edge k+3; with out_ready=1, out_valid=0 next cycle.
//  3. Step cnt_in 14->15->0, each held 4 cycles, out_ready=1 -> out_data 14,15,16; wrap pulses exactly once, on the 16 update.
//  4. cmp_val=5, count 3->5 held -> match pulses 1 cycle with out_data=5; no pulse at 3.
//  5. out_ready=0, two stable updates (1 then 2) -> out_data=2, out_valid=1, overrun=1 and stays 1 until rst.
//  6. cnt_in glitch 3->7->3 with 7 held 1 cycle -> no accept, out_data unchanged.
//     Then rst mid-PEND with cnt_in=6 held -> outputs clear; out_data=6 three cycles after rst drops.

Source files
------------

// File: rtl/cnt_capture_pkg.sv
// Shared definitions for the ripple-counter capture block: raw count width,
// output handshake state encoding and the 4-bit modulo difference helper.
package cnt_capture_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } out_state_e;

  function automatic logic [CNT_W-1:0] delta4(input logic [CNT_W-1:0] cur_v,
                                              input logic [CNT_W-1:0] prev_v);
    return cur_v - prev_v;
  endfunction

endpackage

// File: rtl/ripple_count_capture_sync_3ff.sv
// Three-flop sampling chain for an asynchronous multi-bit count; s2/s3 are
// exposed so the consumer can require two identical samples before trusting it.
module sync_3ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s2_o,
  output logic [W-1:0] s3_o
);

  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2_o = s2_q;
  assign s3_o = s3_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Accumulates stable ripple-counter samples into a wide count with a
// valid/ready output. States: IDLE = nothing pending | PEND = out_data unconsumed.
module ripple_count_capture
  import cnt_capture_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic             match,
  output logic             overrun
);

  logic [CNT_W-1:0] s2, s3;
  logic [CNT_W-1:0] last_q, last_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic             overrun_q, overrun_d;
  out_state_e       state_q, state_d;

  logic             accept;
  logic [CNT_W-1:0] delta;
  logic [WIDTH-1:0] ext_sum;

  sync_3ff #(.W(CNT_W)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_i  (cnt_in),
    .s2_o (s2),
    .s3_o (s3)
  );

  assign accept  = (s2 == s3) && (s2 != last_q);
  assign delta   = delta4(s2, last_q);
  assign ext_sum = ext_q + {{(WIDTH-CNT_W){1'b0}}, delta};

  always_comb begin
    last_d    = last_q;
    ext_d     = ext_q;
    wrap_d    = 1'b0;
    match_d   = 1'b0;
    overrun_d = overrun_q;
    state_d   = state_q;

    if (accept) begin
      last_d  = s2;
      ext_d   = ext_sum;
      wrap_d  = (s2 < last_q);
      match_d = (ext_sum == cmp_val);
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = PEND;
      end
      PEND: begin
        if (out_ready && !accept) state_d = IDLE;
        else if (!out_ready && accept) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= '0;
      ext_q     <= '0;
      wrap_q    <= 1'b0;
      match_q   <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      last_q    <= last_d;
      ext_q     <= ext_d;
      wrap_q    <= wrap_d;
      match_q   <= match_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  // ext only ever changes on accept, so it doubles as the output data register
  assign out_data  = ext_q;
  assign out_valid = (state_q == PEND);
  assign wrap      = wrap_q;
  assign match     = match_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed checks of ripple_count_capture: latency, accumulation, wrap,
// match, overrun, glitch filtering and reset mid-operation.
module tb_ripple_count_capture;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       cnt_in;
  logic [WIDTH-1:0] cmp_val;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             wrap;
  logic             match;
  logic             overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int wrap_cnt;
  int match_cnt;

  ripple_count_capture #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cmp_val   (cmp_val),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .wrap      (wrap),
    .match     (match),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle; pulse counters accumulate across ticks
  task automatic tick();
    @(posedge clk);
    #1;
    if (wrap === 1'b1) wrap_cnt++;
    if (match === 1'b1) match_cnt++;
  endtask

  // present a value and hold it for exactly the accept latency (edges k..k+3)
  task automatic step(input logic [3:0] v);
    cnt_in = v;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cnt_in    = 4'd0;
    cmp_val   = 16'hFFFF;
    out_ready = 1'b0;
    wrap_cnt  = 0;
    match_cnt = 0;

    // 1: reset state, no accept with cnt_in held at 0
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_no_accept", 32'(out_valid), 32'd0);

    // 2: latency 0->1
    out_ready = 1'b1;
    cnt_in = 4'd1;
    repeat (3) tick();
    chk("lat_k2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_k3_valid", 32'(out_valid), 32'd1);
    chk("lat_k3_data", 32'(out_data), 32'd1);
    tick();
    chk("lat_consumed", 32'(out_valid), 32'd0);

    // 3: 14 -> 15 -> 0 with a single wrap on the 16 update
    wrap_cnt = 0;
    step(4'd14);
    chk("s14_data", 32'(out_data), 32'd14);
    chk("s14_valid", 32'(out_valid), 32'd1);
    step(4'd15);
    chk("s15_data", 32'(out_data), 32'd15);
    chk("s15_wrapcnt", 32'(wrap_cnt), 32'd0);
    step(4'd0);
    chk("s16_data", 32'(out_data), 32'd16);
    chk("s16_wrap_now", 32'(wrap), 32'd1);
    tick();
    chk("s16_wrap_gone", 32'(wrap), 32'd0);
    chk("s16_wrapcnt", 32'(wrap_cnt), 32'd1);

    // 4: match at 5, not at 3
    do_reset();
    cmp_val = 16'd5;
    match_cnt = 0;
    step(4'd3);
    chk("m3_data", 32'(out_data), 32'd3);
    chk("m3_matchcnt", 32'(match_cnt), 32'd0);
    step(4'd5);
    chk("m5_data", 32'(out_data), 32'd5);
    chk("m5_match_now", 32'(match), 32'd1);
    tick();
    chk("m5_match_gone", 32'(match), 32'd0);
    chk("m5_matchcnt", 32'(match_cnt), 32'd1);

    // 5: overrun with consumer stalled
    do_reset();
    cmp_val = 16'hFFFF;
    out_ready = 1'b0;
    step(4'd1);
    chk("ov1_data", 32'(out_data), 32'd1);
    chk("ov1_overrun", 32'(overrun), 32'd0);
    repeat (3) tick();
    chk("ov1_hold_data", 32'(out_data), 32'd1);
    chk("ov1_hold_valid", 32'(out_valid), 32'd1);
    step(4'd2);
    chk("ov2_data", 32'(out_data), 32'd2);
    chk("ov2_valid", 32'(out_valid), 32'd1);
    chk("ov2_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("ov_drained", 32'(out_valid), 32'd0);
    chk("ov_sticky", 32'(overrun), 32'd1);

    // 6: glitch filtering, then reset while PEND
    step(4'd3);
    chk("g_base", 32'(out_data), 32'd3);
    tick();
    cnt_in = 4'd7;
    tick();
    cnt_in = 4'd3;
    repeat (6) tick();
    chk("g_data", 32'(out_data), 32'd3);
    chk("g_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    step(4'd5);
    chk("pend_valid", 32'(out_valid), 32'd1);
    chk("pend_data", 32'(out_data), 32'd5);
    cnt_in = 4'd6;
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    wrap_cnt = 0;
    repeat (3) tick();
    chk("post_rst_k2", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'd6);
    chk("post_rst_wrap", 32'(wrap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
